// File: rtl/signed_acc_pkg.sv
// Shared types and constants for the signed burst accumulator.
// Width, saturation limits and FSM states.
package signed_acc_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SAT_MAX = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/signed_burst_accumulator_twos_complement.sv
// 8-bit two's-complement negator (y = -a modulo 256).
// Used for operand negation and magnitude generation.
module twos_complement
  import signed_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] y
);

  assign y = ~a + DATA_W'(1);

endmodule

// File: rtl/signed_burst_accumulator.sv
// Signed add/sub burst accumulator with held result handshake.
// Optional clamping build: define SIGNED_ACC_SATURATE_EN.
module signed_burst_accumulator
  import signed_acc_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_neg,
  output logic [DATA_W-1:0] out_mag,
  output logic              out_ovf
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] neg_data;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] sum_wrap;
  logic [DATA_W-1:0] sum_nx;
  logic [DATA_W-1:0] mag_neg;
  logic [DATA_W:0]   acc_x;
  logic [DATA_W:0]   dat_x;
  logic [DATA_W:0]   true_sum;
  logic              ovf;
  logic              sticky;
  logic              accept;
  logic              last;
  logic              drain;

  twos_complement u_neg (
    .a (in_data),
    .y (neg_data)
  );

  assign operand  = in_sub ? neg_data : in_data;
  assign sum_wrap = acc + operand;

  // 9-bit true result so that subtracting 8'h80 is exact
  assign acc_x    = {acc[DATA_W-1], acc};
  assign dat_x    = {in_data[DATA_W-1], in_data};
  assign true_sum = in_sub ? acc_x - dat_x
                           : acc_x + dat_x;
  assign ovf      = true_sum[DATA_W] ^ true_sum[DATA_W-1];

`ifdef SIGNED_ACC_SATURATE_EN
  assign sum_nx = !ovf             ? sum_wrap :
                  true_sum[DATA_W] ? SAT_MIN  :
                                     SAT_MAX;
`else
  assign sum_nx = sum_wrap;
`endif

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready && !clear;
  assign last      = (cnt == LAST);
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nx = last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && last) begin
            state_nx = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      out_sum <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else if (clear || drain) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc     <= '0;
        cnt     <= '0;
        sticky  <= 1'b0;
        out_sum <= sum_nx;
        out_neg <= sum_nx[DATA_W-1];
        out_ovf <= sticky | ovf;
      end else begin
        acc    <= sum_nx;
        cnt    <= cnt + CW'(1);
        sticky <= sticky | ovf;
      end
    end
  end

  twos_complement u_mag (
    .a (out_sum),
    .y (mag_neg)
  );

  assign out_mag = out_neg ? mag_neg : out_sum;

endmodule

// File: tb/tb_signed_burst_accumulator.sv
// Self-checking bench for signed_burst_accumulator (BURST_LEN=4).
// Expected results come from a behavioural model via a queue.
module tb_signed_burst_accumulator;

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_sub = 1'b0;
  logic       clear = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_neg;
  logic [7:0] out_mag;
  logic       out_ovf;

  int checks = 0;
  int passed = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  signed_burst_accumulator #(.BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_neg   (out_neg),
    .out_mag   (out_mag),
    .out_ovf   (out_ovf)
  );

  task automatic model(input logic [31:0] d, input logic [3:0] s,
                       output exp_t e);
    int acc;
    int t;
    int v;
    logic ov;
    logic [7:0] b;
    logic [7:0] t8;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      v = int'($signed(b));
      t = s[i] ? acc - v : acc + v;
      if (t > 127 || t < -128) ov = 1'b1;
`ifdef SIGNED_ACC_SATURATE_EN
      if (t > 127) t = 127;
      if (t < -128) t = -128;
`endif
      t8  = 8'(t);
      acc = int'($signed(t8));
    end
    e.sum = 8'(acc);
    e.ovf = ov;
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req)
      $display("FAIL %s: got %h required %h", name, act, req);
    else
      passed++;
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [7:0] d, input logic s);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    model(d, s, e);
    q.push_back(e);
    for (int i = 0; i < 3; i++) send(d[8*i +: 8], s[i]);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL early_valid: out_valid=%b required 0", out_valid);
    else passed++;
    send(d[31:24], s[3]);
    checks++;
    if (out_valid !== 1'b1)
      $display("FAIL latency: out_valid=%b required 1", out_valid);
    else passed++;
  endtask

  task automatic collect();
    int n;
    exp_t e;
    logic [7:0] mag;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid || q.size() == 0) begin
      $display("FAIL collect_timeout: out_valid=%b qsize=%0d required 1/>0",
               out_valid, q.size());
      return;
    end
    passed++;
    e = q.pop_front();
    mag = e.sum[7] ? 8'(-int'($signed(e.sum))) : e.sum;
    chk("out_sum", out_sum, e.sum);
    chk("out_neg", {7'd0, out_neg}, {7'd0, e.sum[7]});
    chk("out_mag", out_mag, mag);
    chk("out_ovf", {7'd0, out_ovf}, {7'd0, e.ovf});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", {7'd0, out_valid}, 8'd0);
    chk("drain_ready", {7'd0, in_ready}, 8'd1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_sum", out_sum, 8'd0);
    chk("rst_mag", out_mag, 8'd0);
    chk("rst_ovf", {7'd0, out_ovf}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_burst({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000);
    collect();
  endtask

  task automatic test_mixed();
    run_burst({8'd1, 8'd3, 8'd20, 8'd5}, 4'b1010);
    collect();
  endtask

  task automatic test_overflow();
    run_burst({8'd0, 8'd0, 8'd100, 8'd100}, 4'b0000);
    collect();
    run_burst({8'd0, 8'd0, 8'd0, 8'h80}, 4'b0001);
    collect();
  endtask

  task automatic test_hold();
    logic [7:0] s0;
    run_burst({8'hF6, 8'd7, 8'hFE, 8'd50}, 4'b0100);
    s0 = out_sum;
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {7'd0, out_valid}, 8'd1);
      chk("hold_ready", {7'd0, in_ready}, 8'd0);
      chk("hold_stable", out_sum, s0);
    end
    in_valid = 1'b0;
    collect();
    // a consumed hold-time operand would corrupt this burst
    run_burst({8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000);
    collect();
  endtask

  task automatic test_clear();
    exp_t e;
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", {7'd0, out_valid}, 8'd0);
    chk("clr_ready", {7'd0, in_ready}, 8'd1);
    run_burst({8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000);
    collect();
    run_burst({8'd2, 8'd2, 8'd2, 8'd2}, 4'b0000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    e = q.pop_front();
    chk("clr_hold_valid", {7'd0, out_valid}, 8'd0);
    chk("clr_hold_keep", out_sum, e.sum);
  endtask

  task automatic test_reset_hold();
    run_burst({8'd0, 8'd0, 8'd0, 8'h90}, 4'b0000);
    void'(q.pop_front());
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {7'd0, out_valid}, 8'd0);
    chk("arst_sum", out_sum, 8'd0);
    chk("arst_neg", {7'd0, out_neg}, 8'd0);
    chk("arst_mag", out_mag, 8'd0);
    chk("arst_ovf", {7'd0, out_ovf}, 8'd0);
    chk("arst_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_burst({8'd127, 8'd1, 8'd0, 8'd0}, 4'b0000);
    collect();
    run_burst({8'd100, 8'd100, 8'd0, 8'd0}, 4'b0011);
    collect();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_mixed();
    test_overflow();
    test_hold();
    test_clear();
    test_reset_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
